coupling_mode_ctrl: RTL and testbench
=====================================

# coupling_mode_ctrl

Input-coupling controller for the oscilloscope sample path, placed between the ADC serial deserialiser and the trigger/display pipeline. It debounces three active-low front-panel buttons (AC, DC, GND) and holds the selected coupling mode in a register. It applies that mode to each valid sample: DC passes the sample through, AC subtracts an offset, GND forces zero. The output is a registered signed sample with a valid strobe.

## Interface
Parameters:
- WIDTH, 12, sample width in bits (unsigned input).
- DEBOUNCE, 100, consecutive low cycles required to register a press (≥2).
- AVG_SHIFT, 8, IIR time-constant shift for the auto-offset estimator (used only with the macro).

Ports:
- clk  in  1  sample/system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ac_button  in  1  active-low AC-coupling request.
- dc_button  in  1  active-low DC-coupling request.
- gnd_button  in  1  active-low GND-coupling request.
- in_valid  in  1  serial_in holds a new sample this cycle.
- serial_in  in  WIDTH  unsigned ADC sample.
- offset  in  WIDTH  unsigned AC offset (ignored when the macro is defined).
- result  out  WIDTH+1  signed two's-complement coupled sample.
- out_valid  out  1  result updated this cycle.
- mode  out  2  current mode: 2'b00 DC, 2'b01 AC, 2'b10 GND (2'b11 unused).

## Operation
- Reset values: mode=DC (2'b00), result=0, out_valid=0, all debounce counters=0; auto-offset estimate = 2^(WIDTH-1) when the macro is enabled.
- Debounce, one counter per button, width ceil(log2(DEBOUNCE+1)):
  - Button high: counter←0.
  - Button low and counter<DEBOUNCE: counter←counter+1.
  - Button low and counter==DEBOUNCE: counter holds (saturated).
- Press pulse: asserted on the edge where the counter steps DEBOUNCE-1→DEBOUNCE. A held button produces exactly one pulse. A new pulse needs a release of ≥1 high cycle.
- Mode register: loads on the press-pulse edge.
  - Simultaneous pulses resolve with priority GND > DC > AC.
  - Re-pressing the current mode leaves the mode unchanged.
- Datapath, when in_valid=1 (result uses the mode value held before any same-edge mode update):
  - DC: result = {1'b0, serial_in}.
  - AC: result = $signed({1'b0,serial_in}) − $signed({1'b0,off}). Range −(2^WIDTH−1)…+(2^WIDTH−1). Never overflows, so no saturation is needed. off = offset port, or the estimate when the macro is enabled.
  - GND: result = 0.
- When in_valid=0: result holds its value and out_valid=0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A partially counted press is discarded.

## Timing
- Datapath latency: 1 cycle. out_valid at edge n+1 mirrors in_valid at edge n. Back-to-back in_valid is supported every cycle, with no stall and no backpressure.
- Mode change: mode updates on the edge that ends the DEBOUNCE-th consecutive low-sampled cycle. The first sample processed in the new mode is the one with in_valid on the following cycle.
- Glitch rejection: a low pulse of DEBOUNCE-1 cycles or fewer has no effect.
- Buttons are assumed already synchronised to clk upstream. The block adds no synchroniser.

## Configuration
- Macro COUPLING_AUTO_OFFSET_EN.
- Defined: AC mode uses an internal DC estimate and ignores the offset port.
  - Accumulator width is WIDTH+AVG_SHIFT, with AVG_SHIFT fractional bits.
  - On every in_valid in any mode: acc ← acc + (({serial_in,AVG_SHIFT'b0} − acc) >>> AVG_SHIFT), using a signed difference.
  - The estimate is acc[WIDTH+AVG_SHIFT-1:AVG_SHIFT]. The AC subtraction uses the estimate from before the same-edge update.
- Undefined: no accumulator logic is built, and AC subtracts the offset port value.

## Test plan
- Reset: assert rst mid-stream with counters partly advanced → mode=00, result=0, out_valid=0 within the same cycle; after deassertion, samples pass in DC.
- DC pass-through, WIDTH=12: serial_in=0xABC with in_valid → next cycle result=13'h0ABC, out_valid=1; a gap in in_valid → out_valid=0 and result held.
- AC debounce (macro undefined), DEBOUNCE=100:
  - Hold ac_button low 99 cycles, then high → mode stays 00.
  - Hold low 100 cycles → mode=01 on the 100th edge.
  - With offset=0x800: serial_in=0x7FF → result=−1 (13'h1FFF); serial_in=0xFFF → result=+2047.
- Priority and hold: all three buttons go low on the same cycle for 100 cycles → mode=10 (GND) and result=0 for all inputs. Continued holding produces no further changes. Release, then press AC alone → mode=01.
- AC extremes: offset=0xFFF, serial_in=0 → result=−4095; offset=0, serial_in=0xFFF → result=+4095; no wrap.
- Auto offset (macro defined), AVG_SHIFT=4: feed a constant 0x400 in AC mode for 200 samples → estimate converges to within 1 LSB of 0x400 and result settles to 0 or ±1.

Source files
------------

// File: rtl/coupling_mode_ctrl.sv
// Input-coupling controller: debounced AC/DC/GND buttons select how each ADC sample is coupled.
// Optional macro COUPLING_AUTO_OFFSET_EN replaces the offset port with an internal IIR DC estimate.
module coupling_mode_ctrl #(
  parameter int WIDTH     = 12,
  parameter int DEBOUNCE  = 100,
  parameter int AVG_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ac_button,
  input  logic                    dc_button,
  input  logic                    gnd_button,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        serial_in,
  input  logic [WIDTH-1:0]        offset,
  output logic signed [WIDTH:0]   result,
  output logic                    out_valid,
  output logic [1:0]              mode
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    MODE_DC  = 2'b00,
    MODE_AC  = 2'b01,
    MODE_GND = 2'b10
  } mode_t;

  mode_t                mode_q, mode_d;
  logic [2:0]           btn_n;
  logic [2:0][CW-1:0]   cnt_q;
  logic [2:0]           press;
  logic [WIDTH-1:0]     off;
  logic signed [WIDTH:0] ac_diff;

  // index 0 = AC, 1 = DC, 2 = GND
  assign btn_n = {gnd_button, dc_button, ac_button};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (btn_n[i])
          cnt_q[i] <= '0;
        else if (cnt_q[i] < CW'(DEBOUNCE))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 3; i++)
      press[i] = !btn_n[i] && (cnt_q[i] == CW'(DEBOUNCE - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= MODE_DC;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (press[2])      mode_d = MODE_GND;
    else if (press[1]) mode_d = MODE_DC;
    else if (press[0]) mode_d = MODE_AC;
  end

  assign mode = mode_q;

`ifdef COUPLING_AUTO_OFFSET_EN
  localparam int AW = WIDTH + AVG_SHIFT;

  logic [AW-1:0]       acc_q;
  logic signed [AW:0]  acc_diff;
  logic signed [AW:0]  acc_step;
  logic                unused_offset;

  // Signed difference keeps the step correct when the input drops below the estimate
  assign acc_diff = $signed({1'b0, serial_in, {AVG_SHIFT{1'b0}}}) - $signed({1'b0, acc_q});
  assign acc_step = acc_diff >>> AVG_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc_q <= AW'(1) << (AW - 1);
    else if (in_valid) acc_q <= acc_q + acc_step[AW-1:0];
  end

  assign off           = acc_q[AW-1:AVG_SHIFT];
  assign unused_offset = ^offset;
`else
  localparam int unused_avg_shift = AVG_SHIFT;
  assign off = offset;
`endif

  assign ac_diff = $signed({1'b0, serial_in}) - $signed({1'b0, off});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        unique case (mode_q)
          MODE_DC:  result <= $signed({1'b0, serial_in});
          MODE_AC:  result <= ac_diff;
          default:  result <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coupling_mode_ctrl.sv
// Randomised self-checking bench for coupling_mode_ctrl against a run-length/arithmetic reference model.
module tb_coupling_mode_ctrl;

  localparam int WIDTH = 12;
  localparam int DEB   = 100;
  localparam int W1    = WIDTH + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  ac_button = 1'b1, dc_button = 1'b1, gnd_button = 1'b1;
  logic                  in_valid = 1'b0;
  logic [WIDTH-1:0]      serial_in = '0, offset = '0;
  logic signed [WIDTH:0] result;
  logic                  out_valid;
  logic [1:0]            mode;

  int vectors = 0;
  int errors  = 0;

  // reference model state: low run length per button, mode, output register
  int run [3];
  int m_mode, m_res;
  bit m_val;

  coupling_mode_ctrl #(.WIDTH(WIDTH), .DEBOUNCE(DEB), .AVG_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .ac_button(ac_button), .dc_button(dc_button),
    .gnd_button(gnd_button), .in_valid(in_valid), .serial_in(serial_in),
    .offset(offset), .result(result), .out_valid(out_valid), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) run[i] = 0;
    m_mode = 0; m_res = 0; m_val = 0;
  endfunction

  function automatic void model_step(bit a, bit d, bit g, bit v, int s, int o);
    bit lvl [3];
    bit pr  [3];
    lvl[0] = a; lvl[1] = d; lvl[2] = g;
    for (int i = 0; i < 3; i++) begin
      if (!lvl[i]) begin run[i]++; pr[i] = (run[i] == DEB); end
      else begin run[i] = 0; pr[i] = 0; end
    end
    m_val = v;
    if (v) begin
      if (m_mode == 0)      m_res = s;
      else if (m_mode == 1) m_res = s - o;
      else                  m_res = 0;
    end
    if (pr[2])      m_mode = 2;
    else if (pr[1]) m_mode = 0;
    else if (pr[0]) m_mode = 1;
  endfunction

  task automatic tick(input bit a, input bit d, input bit g, input bit v, input int s, input int o);
    ac_button = a; dc_button = d; gnd_button = g;
    in_valid = v; serial_in = WIDTH'(s); offset = WIDTH'(o);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(a, d, g, v, s, o);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1, 1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) tick(0, 1, 1, 1, int'($urandom_range(0, 4095)), 0);
    rst = 1'b1;
    #1;
    vectors++;
    if (mode !== 2'b00 || result !== 13'sd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got mode=%0d result=%0d valid=%0b, expected 0/0/0", mode, result, out_valid);
    end
    tick(0, 1, 1, 1, 5, 0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(0, 1, 1, 1, int'($urandom_range(0, 4095)), 0);
      vectors++;
      if ({mode, result, out_valid} !== {2'(m_mode), W1'(m_res), m_val}) begin
        errors++;
        $display("FAIL reset_discard: got mode=%0d result=%0d valid=%0b, expected mode=%0d result=%0d valid=%0b",
                 mode, result, out_valid, m_mode, m_res, m_val);
      end
    end
    vectors++;
    if (mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_partial_press: got mode=%0d, expected 0", mode);
    end
    tick(1, 1, 1, 0, 0, 0);
  endtask

  task automatic test_dc_pass();
    tick(1, 1, 1, 1, 'hABC, 0);
    vectors++;
    if (result !== 13'h0ABC || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL dc_pass: got result=%h valid=%0b, expected 0abc/1", result, out_valid);
    end
    tick(1, 1, 1, 0, 'h123, 0);
    vectors++;
    if (result !== 13'h0ABC || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dc_gap_hold: got result=%h valid=%0b, expected 0abc/0", result, out_valid);
    end
  endtask

  task automatic test_ac_debounce();
    for (int i = 0; i < DEB - 1; i++) tick(0, 1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0);
    vectors++;
    if (mode !== 2'b00) begin
      errors++;
      $display("FAIL glitch_reject: got mode=%0d, expected 0", mode);
    end
    for (int i = 0; i < DEB; i++) begin
      tick(0, 1, 1, 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      vectors++;
      if ({mode, result, out_valid} !== {2'(m_mode), W1'(m_res), m_val}) begin
        errors++;
        $display("FAIL ac_press_cycle%0d: got mode=%0d result=%0d valid=%0b, expected mode=%0d result=%0d valid=%0b",
                 i, mode, result, out_valid, m_mode, m_res, m_val);
      end
    end
    vectors++;
    if (mode !== 2'b01) begin
      errors++;
      $display("FAIL ac_press_edge: got mode=%0d, expected 1", mode);
    end
    tick(1, 1, 1, 1, 'h7FF, 'h800);
    vectors++;
    if (result !== 13'h1FFF) begin
      errors++;
      $display("FAIL ac_minus_one: got result=%h, expected 1fff", result);
    end
    tick(1, 1, 1, 1, 'hFFF, 'h800);
    vectors++;
    if (result !== 13'sd2047) begin
      errors++;
      $display("FAIL ac_plus_2047: got result=%0d, expected 2047", result);
    end
  endtask

  task automatic test_ac_extremes();
    tick(1, 1, 1, 1, 0, 'hFFF);
    vectors++;
    if (result !== -13'sd4095) begin
      errors++;
      $display("FAIL ac_min: got result=%0d, expected -4095", result);
    end
    tick(1, 1, 1, 1, 'hFFF, 0);
    vectors++;
    if (result !== 13'sd4095) begin
      errors++;
      $display("FAIL ac_max: got result=%0d, expected 4095", result);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < DEB + 20; i++) begin
      tick(0, 0, 0, 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      vectors++;
      if ({mode, result, out_valid} !== {2'(m_mode), W1'(m_res), m_val}) begin
        errors++;
        $display("FAIL priority_cycle%0d: got mode=%0d result=%0d valid=%0b, expected mode=%0d result=%0d valid=%0b",
                 i, mode, result, out_valid, m_mode, m_res, m_val);
      end
    end
    vectors++;
    if (mode !== 2'b10 || result !== 13'sd0) begin
      errors++;
      $display("FAIL priority_gnd: got mode=%0d result=%0d, expected 2/0", mode, result);
    end
    tick(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < DEB; i++) tick(0, 1, 1, 0, 0, 0);
    vectors++;
    if (mode !== 2'b01) begin
      errors++;
      $display("FAIL gnd_to_ac: got mode=%0d, expected 1", mode);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) begin
      tick(1, 1, 1, 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      vectors++;
      if ({mode, result, out_valid} !== {2'(m_mode), W1'(m_res), m_val}) begin
        errors++;
        $display("FAIL back_to_back%0d: got mode=%0d result=%0d valid=%0b, expected mode=%0d result=%0d valid=%0b",
                 i, mode, result, out_valid, m_mode, m_res, m_val);
      end
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 30; seg++) begin
      int pat = int'($urandom_range(0, 7));
      int len = int'($urandom_range(1, 2 * DEB));
      if ($urandom_range(0, 2) == 0) len = DEB - 1 + int'($urandom_range(0, 2));
      for (int i = 0; i < len; i++) begin
        tick(!pat[0], !pat[1], !pat[2], 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        vectors++;
        if ({mode, result, out_valid} !== {2'(m_mode), W1'(m_res), m_val}) begin
          errors++;
          $display("FAIL random_seg%0d_cyc%0d: got mode=%0d result=%0d valid=%0b, expected mode=%0d result=%0d valid=%0b",
                   seg, i, mode, result, out_valid, m_mode, m_res, m_val);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dc_pass();
    test_ac_debounce();
    test_ac_extremes();
    test_back_to_back();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
